// File: rtl/stream_framer.sv
// Packetizing output stage: re-registers a valid/ready stream and flags out_last on the final
// word of each cfg_length+1 word packet. Define STREAM_FRAMER_COUNT_EN to add sts_frames.
module stream_framer #(
  parameter int DATA_WIDTH = 32,
  parameter int CNTR_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  cfg_enable,
  input  logic [CNTR_WIDTH-1:0] cfg_length,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  sts_busy
`ifdef STREAM_FRAMER_COUNT_EN
  ,
  output logic [31:0]           sts_frames
`endif
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] STOP = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [CNTR_WIDTH-1:0] cnt;
  logic [CNTR_WIDTH-1:0] len_q;
  logic [CNTR_WIDTH-1:0] eff_len;
  logic                  accept;
  logic                  is_last;

  // in_ready never looks at in_valid, so there is no combinational loop through upstream.
  always_comb begin
    in_ready = (state != IDLE) && (!out_valid || out_ready);
    accept   = in_valid && in_ready;
    eff_len  = (cnt == '0) ? cfg_length : len_q;
    is_last  = (cnt == eff_len);
    sts_busy = (state != IDLE) || out_valid;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cfg_enable) state_nxt = RUN;
      end
      RUN: begin
        if (!cfg_enable) begin
          if (accept) begin
            state_nxt = is_last ? IDLE : STOP;
          end else begin
            state_nxt = (cnt == '0) ? IDLE : STOP;
          end
        end
      end
      STOP: begin
        // Finish the packet in flight regardless of cfg_enable.
        if (accept && is_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state     <= IDLE;
      cnt       <= '0;
      len_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (cnt == '0) len_q <= cfg_length;
        cnt       <= is_last ? '0 : cnt + CNTR_WIDTH'(1);
        out_data  <= in_data;
        out_valid <= 1'b1;
        out_last  <= is_last;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifdef STREAM_FRAMER_COUNT_EN
  logic [31:0] frames_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      frames_q <= '0;
    end else if (out_valid && out_ready && out_last) begin
      frames_q <= frames_q + 32'd1;
    end
  end

  assign sts_frames = frames_q;
`endif

endmodule

// File: doc/stream_framer.md
Name: stream_framer

Overview:
Packetizing stage placed directly downstream of the stream buffer. Consumes a continuous valid/ready data stream and re-emits it through a single output register, adding out_last on the final word of each packet. Packet length is runtime-configurable, and start/stop is gated by cfg_enable with packet-boundary-clean stopping. The output feeds DMA writers and other packet-oriented consumers.

Parameters:
DATA_WIDTH, 32, width of in_data/out_data in bits
CNTR_WIDTH, 16, width of cfg_length and the word counter

Ports:
aclk  input  1  clock; all logic on rising edge
areset  input  1  synchronous, active-high reset
cfg_enable  input  1  1 = framing runs; 0 = stop at next packet boundary
cfg_length  input  CNTR_WIDTH  packet length minus one (words per packet = cfg_length+1)
in_data  input  DATA_WIDTH  upstream data
in_valid  input  1  upstream data valid
in_ready  output  1  stage accepts in_data this cycle
out_data  output  DATA_WIDTH  registered data
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts
out_last  output  1  out_data is final word of packet
sts_busy  output  1  state != IDLE or out_valid

Behaviour:
- One clock (aclk); reset synchronous, active-high (areset). All state updates on rising aclk.
- Reset values: state=IDLE, cnt=0, len_q=0, out_valid=0, out_last=0, out_data=0, in_ready=0, sts_busy=0.
- Accept = in_valid & in_ready. in_ready = (state != IDLE) & (~out_valid | out_ready). in_ready is combinational from state and out_ready; no path from in_valid.
- Effective length: eff_len = cfg_length when cnt==0, else len_q. On accept with cnt==0: len_q <= cfg_length. A cfg_length change mid-packet has no effect until the next packet.
- On accept: out_data <= in_data; out_valid <= 1; out_last <= (cnt == eff_len); cnt <= (cnt == eff_len) ? 0 : cnt+1.
- No accept and out_ready=1: out_valid <= 0. out_data and out_last hold.
- Latency: 1 cycle from accept to out_valid. Full throughput of 1 word/cycle when out_ready is held high.
- Backpressure: out_valid=1 & out_ready=0 forces in_ready=0. out_data/out_last are stable while stalled.
- cfg_length=0 gives 1-word packets, with out_last on every word. cfg_length = all-ones gives 2^CNTR_WIDTH words; cnt must not overflow.
- State machine:
  - IDLE: in_ready=0. cfg_enable=1 -> RUN (first accept possible the next cycle).
  - RUN, cfg_enable=0 and cnt==0 and no accept -> IDLE.
  - RUN, cfg_enable=0 and (cnt!=0, or an accept this cycle leaves cnt!=0) -> STOP.
  - RUN, accept of a last word while cfg_enable=0 -> IDLE.
  - STOP: keeps accepting; ignores cfg_enable. Accept of the last word -> IDLE.
- A pending out_valid word drains normally in any state, including after entering IDLE.
- Reset mid-packet: partial packet and any pending output word are discarded; no out_last is emitted. The first packet after reset starts with cnt=0.
- Simultaneous accept and out_ready on the same cycle: the new word replaces the old one, and out_valid stays 1.

Optional Feature:
Macro STREAM_FRAMER_COUNT_EN.
- Defined: adds output sts_frames [31:0]. Reset 0; increments by 1 on each cycle where out_valid & out_ready & out_last; wraps from 0xFFFFFFFF to 0.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan:
- cfg_length=3, cfg_enable=1, in_valid and out_ready always 1, data 0..11 -> out_data 0..11 one cycle after accept; out_last on words 3, 7, 11; no bubbles.
- cfg_length=0, 4 words -> out_last=1 on every word; with the macro, sts_frames=4.
- cfg_length=7; drop cfg_enable after the 3rd accepted word -> words 3..7 still pass, out_last on word 7; state IDLE and in_ready=0 afterwards; no 9th word accepted.
- out_ready toggled 1,0,0,1 with a random in_valid pattern, cfg_length=4 -> out_data/out_last stable during stalls; sequence contiguous; no loss or duplication; out_last every 5 words.
- Change cfg_length from 3 to 1 mid-packet -> current packet still ends at word 4; next packets are 2 words each.
- Assert areset for 1 cycle after 2 words of a 4-word packet -> out_valid=0 next cycle; after re-enable, out_last appears on the 4th word of the new packet.
